multdiv_iter_unit: RTL and testbench

//   Iterative signed 32-bit multiply/divide unit serving the execute stage of the 5-stage pipeline.

---
 rtl/multdiv_iter_unit.sv | 159 +++++++++++++++
 tb/tb_multdiv_iter_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_iter_unit.sv
// Iterative signed 32-bit multiply/divide unit for the execute stage.
// Multiply uses radix-2 Booth recoding, and divide uses non-restoring division on magnitudes.
// Every operation completes exactly WIDTH+1 edges after its start edge.
// It then raises a one-cycle data_resultRDY strobe.
// fsm_state exposes the controller state for observation.
module multdiv_iter_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic [1:0]       fsm_state
);

  // Handshake: ctrl_MULT/ctrl_DIV are sampled on every rising edge.
  // A sampled start always wins, even over a running or finishing op.
  // data_resultRDY is high for exactly one cycle per completed, non-aborted op.
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  logic [CW-1:0]    count;
  // Booth datapath: acc carries one guard bit so subtracting the most negative multiplicand cannot wrap.
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] mplier;
  logic             q_1;
  logic [WIDTH-1:0] mcand;
  // Non-restoring datapath: the partial remainder carries two guard bits.
  // This covers a divisor magnitude of 2^(WIDTH-1).
  logic [WIDTH+1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic             q_neg;
  logic             div_zero;
  logic             div_ovf;

  logic [WIDTH:0]     booth_sum;
  logic [WIDTH:0]     acc_n;
  logic [WIDTH-1:0]   mplier_n;
  logic [WIDTH+1:0]   rem_sh;
  logic [WIDTH+1:0]   rem_n;
  logic [WIDTH-1:0]   quo_n;
  logic [2*WIDTH-1:0] product;
  logic               mul_exc;
  logic [WIDTH-1:0]   div_res;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [CW-1:0]    LAST     = CW'(WIDTH);

  // One Booth step and one non-restoring step from the current registers, plus the final result shaping.
  always_comb begin
    booth_sum = acc;
    case ({mplier[0], q_1})
      2'b01:   booth_sum = acc + {mcand[WIDTH-1], mcand};
      2'b10:   booth_sum = acc - {mcand[WIDTH-1], mcand};
      default: booth_sum = acc;
    endcase
    acc_n    = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
    mplier_n = {booth_sum[0], mplier[WIDTH-1:1]};

    rem_sh = {rem[WIDTH:0], quo[WIDTH-1]};
    rem_n  = rem[WIDTH+1] ? rem_sh + {2'b00, dvs} : rem_sh - {2'b00, dvs};
    quo_n  = {quo[WIDTH-2:0], ~rem_n[WIDTH+1]};

    product = {acc[WIDTH-1:0], mplier};
    mul_exc = !((&product[2*WIDTH-1:WIDTH-1]) || !(|product[2*WIDTH-1:WIDTH-1]));

    if (div_zero)      div_res = '0;
    else if (div_ovf)  div_res = MOST_NEG;
    else if (q_neg)    div_res = -quo;
    else               div_res = quo;

    a_mag = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    b_mag = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
  end

  // Controller and datapath: start, iterate WIDTH times, then register the result and strobe RDY.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      count          <= '0;
      acc            <= '0;
      mplier         <= '0;
      q_1            <= 1'b0;
      mcand          <= '0;
      rem            <= '0;
      quo            <= '0;
      dvs            <= '0;
      q_neg          <= 1'b0;
      div_zero       <= 1'b0;
      div_ovf        <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (ctrl_MULT) begin
        state  <= MUL;
        count  <= '0;
        acc    <= '0;
        mplier <= data_operandB;
        q_1    <= 1'b0;
        mcand  <= data_operandA;
      end else if (ctrl_DIV) begin
        state    <= DIV;
        count    <= '0;
        rem      <= '0;
        quo      <= a_mag;
        dvs      <= b_mag;
        q_neg    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        div_zero <= (data_operandB == '0);
        div_ovf  <= (data_operandA == MOST_NEG) && (data_operandB == ALL_ONES);
      end else begin
        case (state)
          MUL: begin
            if (count == LAST) begin
              data_result    <= product[WIDTH-1:0];
              data_exception <= mul_exc;
              data_resultRDY <= 1'b1;
              state          <= DONE;
            end else begin
              acc    <= acc_n;
              mplier <= mplier_n;
              q_1    <= mplier[0];
              count  <= count + 1'b1;
            end
          end
          DIV: begin
            if (count == LAST) begin
              data_result    <= div_res;
              data_exception <= div_zero | div_ovf;
              data_resultRDY <= 1'b1;
              state          <= DONE;
            end else begin
              rem   <= rem_n;
              quo   <= quo_n;
              count <= count + 1'b1;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_multdiv_iter_unit.sv
// Testbench for multdiv_iter_unit.
// A driver issues operations and pushes the reference result and expected completion cycle.
// A negedge monitor pops and checks every completion strobe against those queues.
module tb_multdiv_iter_unit;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] data_operandA = '0;
  logic [W-1:0] data_operandB = '0;
  logic         ctrl_MULT = 1'b0;
  logic         ctrl_DIV = 1'b0;
  logic [W-1:0] data_result;
  logic         data_exception;
  logic         data_resultRDY;
  logic [1:0]   fsm_state;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  logic [W:0] exp_q[$];
  int         cyc_q[$];

  multdiv_iter_unit #(.WIDTH(W)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .fsm_state      (fsm_state)
  );

  // Clock and edge counter
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
  endtask

  // Reference model: plain signed arithmetic
  function automatic logic [W:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    longint p;
    logic [W-1:0] lo;
    p  = longint'($signed(a)) * longint'($signed(b));
    lo = p[W-1:0];
    return {(p != longint'($signed(lo))), lo};
  endfunction

  function automatic logic [W:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
    int sa, sb, q;
    if (b == '0) return {1'b1, 32'h0};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h8000_0000};
    sa = $signed(a);
    sb = $signed(b);
    q  = sa / sb;
    return {1'b0, q[W-1:0]};
  endfunction

  // Driver: start edge is the next rising edge; any op that would complete at or after it is aborted.
  task automatic start_op(input bit is_mul, input logic [W-1:0] a, input logic [W-1:0] b);
    int s;
    @(negedge clock);
    s = cyc + 1;
    while (cyc_q.size() > 0 && cyc_q[$] >= s) begin
      void'(cyc_q.pop_back());
      void'(exp_q.pop_back());
    end
    exp_q.push_back(is_mul ? ref_mul(a, b) : ref_div(a, b));
    cyc_q.push_back(s + 33);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT = is_mul;
    ctrl_DIV  = !is_mul;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 80) begin
      @(negedge clock);
      n++;
    end
    if (exp_q.size() > 0) begin
      check("drain_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      cyc_q.delete();
    end
  endtask

  task automatic run_op(input bit is_mul, input logic [W-1:0] a, input logic [W-1:0] b);
    start_op(is_mul, a, b);
    drain();
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(0, 5))
      0: v = '0;
      1: v = 32'h8000_0000;
      2: v = 32'hFFFF_FFFF;
      3: begin
        v = W'($urandom_range(1, 20));
        if ($urandom_range(0, 1) == 1) v = -v;
      end
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Scoreboard monitor: every strobe must match the head entry in value and cycle; a missed cycle fails too.
  always @(negedge clock) begin
    if (mon_en && !reset) begin
      if (data_resultRDY) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rdy", 64'd1, 64'd0);
        end else begin
          check("rdy_cycle", 64'(cyc), 64'(cyc_q[0]));
          check("result", 64'(data_result), 64'(exp_q[0][W-1:0]));
          check("exception", 64'(data_exception), 64'(exp_q[0][W]));
          void'(exp_q.pop_front());
          void'(cyc_q.pop_front());
        end
      end else if (cyc_q.size() > 0 && cyc_q[0] <= cyc) begin
        check("missing_rdy", 64'd0, 64'd1);
        void'(exp_q.pop_front());
        void'(cyc_q.pop_front());
      end
    end
  end

  // Stimulus
  initial begin
    int d;
    #7;
    check("reset_result", 64'(data_result), 64'd0);
    check("reset_exc", 64'(data_exception), 64'd0);
    check("reset_rdy", 64'(data_resultRDY), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    mon_en = 1'b1;

    // Directed values
    run_op(1'b1, 32'd7, -32'sd3);
    run_op(1'b1, 32'h0001_0000, 32'h0001_0000);
    run_op(1'b1, 32'h8000_0000, 32'd1);
    run_op(1'b0, -32'sd7, 32'd2);
    run_op(1'b0, 32'd7, -32'sd2);
    run_op(1'b0, 32'd100, 32'd7);
    run_op(1'b0, 32'd5, 32'd0);
    run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(1'b1, 32'h8000_0000, 32'h8000_0000);

    // Abort: DIV issued at the tenth edge of a running MULT
    start_op(1'b1, 32'd3, 32'd4);
    repeat (9) @(posedge clock);
    start_op(1'b0, 32'd100, 32'd7);
    drain();

    // Random ops with random spacing: aborts, start during DONE, and idle gaps
    for (int i = 0; i < 150; i++) begin
      start_op($urandom_range(0, 1) == 1, pick(), pick());
      d = $urandom_range(1, 40);
      if (d > 1) repeat (d - 1) @(posedge clock);
    end
    drain();

    // Reset in the middle of a MULT
    start_op(1'b1, 32'd123, 32'd456);
    repeat (20) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    exp_q.delete();
    cyc_q.delete();
    check("midreset_result", 64'(data_result), 64'd0);
    check("midreset_exc", 64'(data_exception), 64'd0);
    check("midreset_rdy", 64'(data_resultRDY), 64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    check("post_reset_result", 64'(data_result), 64'd0);
    run_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    repeat (3) @(negedge clock);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Global time limit
  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
